// File: rtl/wptr_full_lvl.sv
// Write-side pointer and flag logic for an asynchronous FIFO: Gray write pointer,
// full / almost-full flags, fill level and a sticky overflow flag.
module wptr_full_lvl #(
    parameter int ADDRSIZE    = 4,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic                wovf_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                woverflow
);

    localparam int DEPTH = 1 << ADDRSIZE;

    if (ADDRSIZE < 2 || AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_params
        $error("wptr_full_lvl: illegal ADDRSIZE/AFULL_LEVEL combination");
    end

    localparam logic [ADDRSIZE:0] AFULL_LVL = (ADDRSIZE + 1)'(AFULL_LEVEL);

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbinnext;
    logic [ADDRSIZE:0] wgraynext;
    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] lvlnext;
    logic              push;
    logic              full_next;
    logic              afull_next;

    // winc is a request with no back-pressure handshake: a word is taken on
    // every edge where winc=1 and wfull=0; requests while full are dropped
    // and recorded in woverflow.
    assign push = winc & ~wfull;

    always_comb begin
        rbin = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            rbin = rbin ^ (wq2_rptr >> i);
        end
    end

    assign wbinnext   = wbin + {{ADDRSIZE{1'b0}}, push};
    assign wgraynext  = (wbinnext >> 1) ^ wbinnext;
    assign lvlnext    = wbinnext - rbin;
    assign full_next  = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
    assign afull_next = (lvlnext >= AFULL_LVL);
    assign waddr      = wbin[ADDRSIZE-1:0];

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            woverflow    <= 1'b0;
        end else begin
            wbin         <= wbinnext;
            wptr         <= wgraynext;
            wfull        <= full_next;
            walmost_full <= afull_next;
            wlevel       <= lvlnext;
            // A rejected write in the same cycle as a clear keeps the flag set.
            if (winc && wfull) begin
                woverflow <= 1'b1;
            end else if (wovf_clr) begin
                woverflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wptr_full_lvl.sv
// Bench for wptr_full_lvl: counts-based reference model feeds an expected queue,
// a monitor compares every cycle after the active edge.
module tb_wptr_full_lvl;

    localparam int ADDRSIZE = 4;
    localparam int DEPTH    = 16;
    localparam int AFULL    = 12;

    logic                wclk;
    logic                wrst;
    logic                winc;
    logic [ADDRSIZE:0]   wq2_rptr;
    logic                wovf_clr;
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE:0]   wptr;
    logic                wfull;
    logic                walmost_full;
    logic [ADDRSIZE:0]   wlevel;
    logic                woverflow;

    wptr_full_lvl #(.ADDRSIZE(ADDRSIZE), .AFULL_LEVEL(AFULL)) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .wovf_clr     (wovf_clr),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .woverflow    (woverflow)
    );

    // ---------------- clock / reset ----------------
    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    // packed view: {waddr[3:0], wptr[4:0], wfull, walmost_full, wlevel[4:0], woverflow}
    logic [16:0] exp_q[$];
    int          n_cmp;
    int          n_bad;

    // reference model: plain counts of words written and words read
    int   m_wcount;
    int   m_rcount;
    logic m_full;
    logic m_ovf;
    int   wrap_max_lvl;
    int   wrap_full_seen;
    logic in_wrap;

    function automatic logic [4:0] to_gray(input int b);
        logic [4:0] v;
        v = 5'(b % 32);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [16:0] dut_vec();
        return {waddr, wptr, wfull, walmost_full, wlevel, woverflow};
    endfunction

    task automatic check(input string name, input int got, input int req);
        n_cmp++;
        if (got != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic [16:0] mon_exp;
    logic [16:0] mon_got;
    always @(posedge wclk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_got = dut_vec();
            n_cmp++;
            if (mon_got !== mon_exp) begin
                n_bad++;
                $display("FAIL cycle_outputs: got waddr=%0d wptr=%b full=%b afull=%b lvl=%0d ovf=%b, required waddr=%0d wptr=%b full=%b afull=%b lvl=%0d ovf=%b (t=%0t)",
                         mon_got[16:13], mon_got[12:8], mon_got[7], mon_got[6], mon_got[5:1], mon_got[0],
                         mon_exp[16:13], mon_exp[12:8], mon_exp[7], mon_exp[6], mon_exp[5:1], mon_exp[0], $time);
            end
            if (in_wrap) begin
                if (int'(wlevel) > wrap_max_lvl) wrap_max_lvl = int'(wlevel);
                if (wfull) wrap_full_seen++;
            end
        end
    end

    // ---------------- driver ----------------
    // Applies inputs for one cycle, predicts the post-edge outputs, and returns
    // at the following falling edge.
    task automatic step(input logic inc, input logic clr, input int rnew);
        int   lvl;
        logic acc;
        winc     = inc;
        wovf_clr = clr;
        wq2_rptr = to_gray(rnew);
        acc      = inc && !m_full;
        m_ovf    = (inc && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
        if (acc) m_wcount++;
        m_rcount = rnew;
        lvl      = m_wcount - m_rcount;
        m_full   = (lvl == DEPTH);
        exp_q.push_back({4'(m_wcount % 16), to_gray(m_wcount), m_full,
                         (lvl >= AFULL) ? 1'b1 : 1'b0, 5'(lvl), m_ovf});
        @(negedge wclk);
    endtask

    task automatic model_reset();
        m_wcount = 0;
        m_rcount = 0;
        m_full   = 1'b0;
        m_ovf    = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_waddr"}, int'(waddr), 0);
        check({tag, "_wptr"}, int'(wptr), 0);
        check({tag, "_wfull"}, int'(wfull), 0);
        check({tag, "_afull"}, int'(walmost_full), 0);
        check({tag, "_wlevel"}, int'(wlevel), 0);
        check({tag, "_wovf"}, int'(woverflow), 0);
    endtask

    // ---------------- stimulus ----------------
    int hist[$];
    int rn;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        in_wrap = 1'b0;
        wrap_max_lvl = 0;
        wrap_full_seen = 0;
        model_reset();
        wrst = 1'b1;
        winc = 1'b0;
        wovf_clr = 1'b0;
        wq2_rptr = '0;

        repeat (2) @(negedge wclk);
        check_all_zero("reset");
        wrst = 1'b0;

        // fill from empty, first write on the first edge after release
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 0);
        check("fill_wptr", int'(wptr), 5'b11000);

        // overflow then clear, then simultaneous overflow and clear
        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 0);
        step(1'b1, 1'b1, 0);
        check("ovf_set_wins", int'(woverflow), 1);
        step(1'b0, 1'b1, 0);

        // drain by read-pointer moves only
        step(1'b0, 1'b0, 1);
        check("drain_lvl15", int'(wlevel), 15);
        step(1'b0, 1'b0, 5);
        check("drain_lvl11", int'(wlevel), 11);

        // write and read in the same cycle
        step(1'b1, 1'b0, 6);
        check("wr_rd_same_lvl", int'(wlevel), 11);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rn = m_rcount + $urandom_range(0, 2);
            if (rn > m_wcount) rn = m_wcount;
            if ($urandom_range(0, 3) == 0) rn = m_rcount;
            step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0, rn);
        end

        // wrap with the read pointer trailing two cycles behind
        step(1'b0, 1'b1, m_wcount);
        hist.delete();
        hist.push_back(m_wcount);
        hist.push_back(m_wcount);
        in_wrap = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, hist[hist.size() - 2]);
            hist.push_back(m_wcount);
        end
        in_wrap = 1'b0;
        check("wrap_max_level_le3", (wrap_max_lvl <= 3) ? 1 : 0, 1);
        check("wrap_no_full", wrap_full_seen, 0);

        // reset in the middle of a fill
        step(1'b0, 1'b0, m_wcount);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, m_rcount);
        check("pre_reset_lvl9", int'(wlevel), 9);
        winc = 1'b0;
        #1;
        wrst = 1'b1;
        wq2_rptr = '0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        #1;
        wrst = 1'b0;
        step(1'b1, 1'b0, 0);
        check("post_reset_waddr", int'(waddr), 1);
        check("post_reset_lvl", int'(wlevel), 1);
        step(1'b0, 1'b0, 0);

        // bounded wait for the monitor to empty the queue
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge wclk);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
